eda_push_stack: RTL
===================

// Module: eda_push_stack
// PURPOSE
// - LIFO of pending pixel addresses for the regional-maximum flood traversal.
// - Takes the 8-neighbour address window plus push mask from the neighbour-compare stage.
// - Serialises the masked neighbours into the stack at one per cycle.
// - Pops one address per request; the popped address becomes the next center_addr and new_pixel for the iterated RAM.
// PARAMETERS
// - M             16               image rows
// - N             16               image columns
// - ADDR_WIDTH    $clog2(M*N)      pixel address width, {i, j}
// - DEPTH         M*N              stack entries
// - CNT_WIDTH     $clog2(DEPTH+1)  occupancy counter width
// PORTS
// - clk            in   1             single clock; all logic on posedge
// - reset          in   1             synchronous, active-high
// - clear          in   1             synchronous flush for a new region; same effect as reset
// - push_valid     in   1             neighbour window presented
// - push_ready     out  1             high only in IDLE
// - push_positions in   8             bit7 = upleft, up, upright, left, right, downleft, down, bit0 = downright
// - neighbor_addrs in   8*ADDR_WIDTH  slice k = address of neighbour bit k
// - pop_req        in   1             request top entry
// - pop_valid      out  1             pop_addr valid; 1-cycle pulse
// - pop_addr       out  ADDR_WIDTH    popped address
// - empty          out  1             count == 0
// - full           out  1             count == DEPTH
// - count          out  CNT_WIDTH     current occupancy
// - overflow       out  1             sticky; a push was dropped because the stack was full
// BEHAVIOUR
// - Reset / clear values: push_ready=1, pop_valid=0, pop_addr=0, count=0, overflow=0, empty=1, full=0, FSM=IDLE.
// - Reset or clear mid-DRAIN abandons the held mask. Stack memory contents are not cleared.
// - FSM states: IDLE, DRAIN.
// - IDLE -> DRAIN: push_valid & push_ready & (push_positions != 0). Mask and addresses are latched.
// - push_valid with an all-zero mask: accepted, no-op, FSM stays IDLE.
// - DRAIN: each cycle, write the lowest set bit of the held mask at mem[count], count+1, then clear that bit.
// - DRAIN -> IDLE: in the cycle the last bit is written. push_ready rises the next cycle.
// - Latency: n set bits take n cycles. Entries land bit0 first, so the highest set bit is on top.
// - Pop accepted when pop_req & ~empty.
// - Pop response: pop_addr <= mem[count-1], pop_valid=1 the next cycle, count-1.
// - pop_req while empty: ignored, pop_valid=0, no error.
// - Pop and a DRAIN write in the same cycle: the pop wins. The drain stalls that cycle; mask and state are unchanged.
// - DRAIN write while full: entry dropped, overflow set, bit cleared, draining continues.
// - count never exceeds DEPTH and never goes below 0. full and empty are combinational from count.
// CONFIGURATION
// - Macro EDA_PUSH_STACK_WATERMARK_EN.
// - Defined: adds output max_count [CNT_WIDTH] = peak count since the last reset/clear. Updated the same cycle count changes.
// - Undefined: no max_count port and no watermark logic; behaviour otherwise identical.
// STRUCTURE
// - Package eda_pkg holds:
//   - NEIGHBOR_NUM = 8
//   - typedef addr_t
//   - typedef enum logic {IDLE, DRAIN} push_state_e
//   - the neighbour bit-index constants (UPLEFT_IDX = 7 .. DOWNRIGHT_IDX = 0)
// - One sub-module, eda_stack_mem: DEPTH x ADDR_WIDTH, one synchronous write port, one registered read port.
// - FSM, priority encoder and counter stay in eda_push_stack.
// TESTING
// - Push mask 8'b1000_0001, addrs k -> 8'h10+k.
//   - Expect: push_ready low for 2 cycles, count=2.
//   - Then 2 pops return 8'h17, then 8'h10. empty=1.
// - Push mask 8'h00 with push_valid=1.
//   - Expect: push_ready stays 1, count stays 0, no FSM change.
// - Mask 8'hFF and pop_req held high on cycle 3 of DRAIN.
//   - Expect: the drain stalls one cycle, the pop returns the bit1 address, final count=7.
// - Fill to DEPTH=256, then push mask 8'h03.
//   - Expect: full=1, count=256, overflow=1 and sticky.
//   - Expect: clear drops count to 0 and overflow to 0.
// - Assert reset on cycle 2 of an 8'hFF drain.
//   - Expect next cycle: count=0, push_ready=1, pop_valid=0.
// - With EDA_PUSH_STACK_WATERMARK_EN, push 5 then pop 3.
//   - Expect: max_count=5, count=2. After clear, max_count=0.

Source files
------------

// File: rtl/eda_pkg.sv
// Shared types and constants for the flood-traversal push stack.
package eda_pkg;

  localparam int NEIGHBOR_NUM = 8;
  localparam int IDX_WIDTH    = $clog2(NEIGHBOR_NUM);

  // Default image geometry (16x16) used by the address type.
  localparam int DEF_M          = 16;
  localparam int DEF_N          = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_M * DEF_N);

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {IDLE, DRAIN} push_state_e;

  localparam int UPLEFT_IDX    = 7;
  localparam int UP_IDX        = 6;
  localparam int UPRIGHT_IDX   = 5;
  localparam int LEFT_IDX      = 4;
  localparam int RIGHT_IDX     = 3;
  localparam int DOWNLEFT_IDX  = 2;
  localparam int DOWN_IDX      = 1;
  localparam int DOWNRIGHT_IDX = 0;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [IDX_WIDTH-1:0] lowest_set_idx(input logic [NEIGHBOR_NUM-1:0] mask);
    lowest_set_idx = '0;
    for (int k = NEIGHBOR_NUM - 1; k >= 0; k--) begin
      if (mask[k]) lowest_set_idx = IDX_WIDTH'(k);
    end
  endfunction

endpackage

// File: rtl/eda_stack_mem.sv
// Stack storage: DEPTH x ADDR_WIDTH, synchronous write, registered read.
module eda_stack_mem #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int PTR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PTR_WIDTH-1:0]  wr_ptr,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PTR_WIDTH-1:0]  rd_ptr,
  output logic [ADDR_WIDTH-1:0] rd_data
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; only the occupancy count
  // decides which entries are meaningful, and a reset port would block RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/eda_push_stack.sv
// LIFO of pending pixel addresses; serialises a masked 8-neighbour window one entry per cycle.
// Optional EDA_PUSH_STACK_WATERMARK_EN adds a max_count peak-occupancy output.
module eda_push_stack
  import eda_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M * N),
  parameter int DEPTH      = M * N,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 push_valid,
  output logic                                 push_ready,
  input  logic [NEIGHBOR_NUM-1:0]              push_positions,
  input  logic [NEIGHBOR_NUM*ADDR_WIDTH-1:0]   neighbor_addrs,
  input  logic                                 pop_req,
  output logic                                 pop_valid,
  output logic [ADDR_WIDTH-1:0]                pop_addr,
  output logic                                 empty,
  output logic                                 full,
  output logic [CNT_WIDTH-1:0]                 count,
  output logic                                 overflow
`ifdef EDA_PUSH_STACK_WATERMARK_EN
  ,
  output logic [CNT_WIDTH-1:0]                 max_count
`endif
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  push_state_e                        state, state_next;
  logic [NEIGHBOR_NUM-1:0]            mask_q, mask_next;
  logic [NEIGHBOR_NUM*ADDR_WIDTH-1:0] addrs_q;
  logic [CNT_WIDTH-1:0]               count_next;
  logic [IDX_WIDTH-1:0]               bit_idx;
  logic [ADDR_WIDTH-1:0]              drain_data;
  logic                               flush, push_accept, pop_accept;
  logic                               drain_step, wr_en, drop;

  assign flush       = reset | clear;
  assign push_ready  = (state == IDLE);
  assign empty       = (count == '0);
  assign full        = (count == CNT_WIDTH'(DEPTH));
  assign push_accept = push_valid & push_ready & (|push_positions);
  assign pop_accept  = pop_req & ~empty;

  // A pop in the same cycle freezes the drain so the two never touch the pointer together.
  assign drain_step  = (state == DRAIN) & ~pop_accept;
  assign wr_en       = drain_step & ~full;
  assign drop        = drain_step & full;
  assign bit_idx     = lowest_set_idx(mask_q);
  assign drain_data  = addrs_q[int'(bit_idx) * ADDR_WIDTH +: ADDR_WIDTH];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    mask_next  = mask_q;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (push_accept) begin
          state_next = DRAIN;
          mask_next  = push_positions;
        end
      end
      DRAIN: begin
        if (drain_step) begin
          mask_next = mask_q & (mask_q - 1'b1);
          if (mask_next == '0) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop_accept)  count_next = count - 1'b1;
    else if (wr_en)  count_next = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      mask_q    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      state     <= state_next;
      mask_q    <= mask_next;
      count     <= count_next;
      overflow  <= overflow | drop;
      pop_valid <= pop_accept;
    end
  end

  // The held address window is only read while mask_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_accept) addrs_q <= neighbor_addrs;
  end

`ifdef EDA_PUSH_STACK_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (flush)                       max_count <= '0;
    else if (count_next > max_count) max_count <= count_next;
  end
`else
  // Watermark tracking is compiled out.
`endif

  eda_stack_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (flush),
    .wr_en   (wr_en),
    .wr_ptr  (PTR_WIDTH'(count)),
    .wr_data (drain_data),
    .rd_en   (pop_accept),
    .rd_ptr  (PTR_WIDTH'(count - 1'b1)),
    .rd_data (pop_addr)
  );

endmodule
